uart_rx_fifo: RTL and testbench

//  Byte FIFO directly downstream of the UART receiver. Captures each received byte
//  on its one-cycle valid strobe and presents it on a valid/ready stream to the

---
 rtl/uart_rx_fifo_if.sv | 26 ++
 rtl/uart_rx_fifo.sv | 90 +++++++++
 tb/tb_uart_rx_fifo.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Stream bundle between the UART receiver, the RX byte FIFO and its consumer.
// The slave side is the FIFO itself; the master side is whatever drives it.
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]          in_data;
  logic                in_valid;
  logic [7:0]          out_data;
  logic                out_valid;
  logic                out_ready;
  logic [DEPTH_LOG2:0] level;
  logic                almost_full;
  logic                overflow;
  logic                clr_overflow;
  logic [DEPTH_LOG2:0] line_count;

  modport master (
    output in_data, in_valid, out_ready, clr_overflow,
    input  out_data, out_valid, level, almost_full, overflow, line_count
  );

  modport slave (
    input  in_data, in_valid, out_ready, clr_overflow,
    output out_data, out_valid, level, almost_full, overflow, line_count
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO behind the UART receiver: byte visible 1 cycle after its strobe; drops and flags sticky overflow when full with no pop.
// Optional newline counter enabled by UART_RX_FIFO_LINE_CNT_EN (otherwise line_count is tied to 0).
module uart_rx_fifo #(
  parameter int DEPTH_LOG2  = 4,
  parameter int AFULL_LEVEL = 12
) (
  input logic          clk,
  input logic          rst_n,
  uart_rx_fifo_if.slave bus
);
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [PW-1:0] AFULL = PW'(AFULL_LEVEL);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] fillLevel;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          dropByte;
  logic          overflowQ;
  logic [7:0]    headByte;

  // Extra pointer bit distinguishes full from empty when the low bits match.
  assign fillLevel = wrPtr - rdPtr;
  assign empty     = (wrPtr == rdPtr);
  assign full      = (wrPtr[PW-1] != rdPtr[PW-1]) &&
                     (wrPtr[PW-2:0] == rdPtr[PW-2:0]);
  assign pop       = !empty && bus.out_ready;
  assign push      = bus.in_valid && (!full || pop);
  assign dropByte  = bus.in_valid && full && !pop;
  assign headByte  = mem[rdPtr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr[DEPTH_LOG2-1:0]] <= bus.in_data;
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflowQ <= 1'b0;
    end else if (dropByte) begin
      overflowQ <= 1'b1;
    end else if (bus.clr_overflow) begin
      overflowQ <= 1'b0;
    end
  end

  assign bus.out_valid   = !empty;
  assign bus.out_data    = empty ? 8'h00 : headByte;
  assign bus.level       = fillLevel;
  assign bus.almost_full = (fillLevel >= AFULL);
  assign bus.overflow    = overflowQ;

`ifdef UART_RX_FIFO_LINE_CNT_EN
  logic [PW-1:0] lineCnt;
  logic          lineIn;
  logic          lineOut;

  assign lineIn  = push && (bus.in_data == 8'h0A);
  assign lineOut = pop && (headByte == 8'h0A);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lineCnt <= '0;
    end else if (lineIn && !lineOut) begin
      lineCnt <= lineCnt + PW'(1);
    end else if (lineOut && !lineIn) begin
      lineCnt <= lineCnt - PW'(1);
    end
  end

  assign bus.line_count = lineCnt;
`else
  assign bus.line_count = '0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a reference model tracks count, overflow and newlines.
module tb_uart_rx_fifo;
  localparam int DL = 4;
  localparam int PW = DL + 1;
  localparam int DEPTH = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   mCount;
  logic mOvf;
  int   mLines;
  logic [7:0] sbq[$];

  uart_rx_fifo_if #(.DEPTH_LOG2(DL)) bus ();

  uart_rx_fifo #(.DEPTH_LOG2(DL), .AFULL_LEVEL(12)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int expLines();
`ifdef UART_RX_FIFO_LINE_CNT_EN
    return mLines;
`else
    return 0;
`endif
  endfunction

  task automatic modelReset();
    mCount = 0;
    mOvf   = 1'b0;
    mLines = 0;
    sbq.delete();
  endtask

  // One clock: drive inputs, compare state against model, predict next state.
  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic c);
    logic       doPop;
    logic       doPush;
    logic       isFull;
    logic [7:0] exp;
    bus.in_valid     = v;
    bus.in_data      = d;
    bus.out_ready    = r;
    bus.clr_overflow = c;
    #1;
    checks++;
    if (bus.level !== PW'(mCount))
      begin errors++; $display("FAIL level got %0d want %0d", bus.level, mCount); end
    checks++;
    if (bus.out_valid !== (mCount != 0))
      begin errors++; $display("FAIL out_valid got %b want %b", bus.out_valid, mCount != 0); end
    checks++;
    if (bus.almost_full !== (mCount >= 12))
      begin errors++; $display("FAIL almost_full got %b want %b", bus.almost_full, mCount >= 12); end
    checks++;
    if (bus.overflow !== mOvf)
      begin errors++; $display("FAIL overflow got %b want %b", bus.overflow, mOvf); end
    checks++;
    if (bus.line_count !== PW'(expLines()))
      begin errors++; $display("FAIL line_count got %0d want %0d", bus.line_count, expLines()); end
    doPop = r && (mCount != 0);
    if (doPop) begin
      exp = sbq.pop_front();
      checks++;
      if (bus.out_data !== exp)
        begin errors++; $display("FAIL out_data got %h want %h", bus.out_data, exp); end
      if (exp == 8'h0A) mLines--;
    end else if (mCount == 0) begin
      checks++;
      if (bus.out_data !== 8'h00)
        begin errors++; $display("FAIL out_data_masked got %h want 00", bus.out_data); end
    end
    isFull = (mCount == DEPTH);
    doPush = v && (!isFull || doPop);
    if (doPush) begin
      sbq.push_back(d);
      if (d == 8'h0A) mLines++;
    end
    mCount = mCount + int'(doPush) - int'(doPop);
    if (v && isFull && !doPop) mOvf = 1'b1;
    else if (c)                mOvf = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && mCount > 0; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.level !== '0)
      begin errors++; $display("FAIL drain_empty got valid %b level %0d want 0 0", bus.out_valid, bus.level); end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.level !== '0 || bus.overflow !== 1'b0 ||
        bus.out_data !== 8'h00 || bus.almost_full !== 1'b0 || bus.line_count !== '0)
      begin errors++; $display("FAIL reset_state got v%b l%0d o%b d%h a%b n%0d want all zero",
        bus.out_valid, bus.level, bus.overflow, bus.out_data, bus.almost_full, bus.line_count); end
  endtask

  task automatic test_basic();
    step(1'b1, 8'h41, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b0);
    step(1'b1, 8'h43, 1'b0, 1'b0);
    checks++;
    if (bus.level !== PW'(3) || bus.out_data !== 8'h41)
      begin errors++; $display("FAIL basic_fill got level %0d data %h want 3 41", bus.level, bus.out_data); end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 17; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    checks++;
    if (bus.level !== PW'(16) || bus.almost_full !== 1'b1 || bus.overflow !== 1'b1)
      begin errors++; $display("FAIL overflow_full got l%0d a%b o%b want 16 1 1",
        bus.level, bus.almost_full, bus.overflow); end
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (bus.overflow !== 1'b0)
      begin errors++; $display("FAIL overflow_clear got %b want 0", bus.overflow); end
    drain();
  endtask

  task automatic test_full_stream();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'(8'hA0 + i), 1'b1, 1'b0);
    checks++;
    if (bus.level !== PW'(16) || bus.overflow !== 1'b0)
      begin errors++; $display("FAIL stream_full got l%0d o%b want 16 0", bus.level, bus.overflow); end
    drain();
  endtask

  task automatic test_empty_simul();
    step(1'b1, 8'h55, 1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h55 || bus.level !== PW'(1))
      begin errors++; $display("FAIL empty_simul got v%b d%h l%0d want 1 55 1",
        bus.out_valid, bus.out_data, bus.level); end
    drain();
  endtask

  task automatic test_line_count();
    logic [7:0] s [4];
    s = '{8'h41, 8'h0A, 8'h42, 8'h0A};
    for (int i = 0; i < 4; i++) step(1'b1, s[i], 1'b0, 1'b0);
    checks++;
    if (bus.line_count !== PW'(expLines()))
      begin errors++; $display("FAIL line_count_fill got %0d want %0d", bus.line_count, expLines()); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h0A, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 17; i++) step(1'b1, 8'h0A, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.level !== '0 || bus.overflow !== 1'b0 ||
        bus.out_data !== 8'h00 || bus.line_count !== '0)
      begin errors++; $display("FAIL reset_mid got v%b l%0d o%b d%h n%0d want all zero",
        bus.out_valid, bus.level, bus.overflow, bus.out_data, bus.line_count); end
    modelReset();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 8'h33, 1'b0, 1'b0);
    drain();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    modelReset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.out_ready = 1'b0;
    bus.clr_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_basic();
    test_overflow();
    test_full_stream();
    test_empty_simul();
    test_line_count();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
